spi_ram_slave_ctrl: RTL and testbench
=====================================

Name: spi_ram_slave_ctrl

Overview:
- SPI slave front-end that sequences the team's single-port RAM.
- Deserialises 10-bit command words from MOSI and hands each one to the RAM as a one-cycle rx_valid/rx_data pulse.
- On read-data commands, captures the RAM's registered reply (tx_valid/tx_data) and serialises it MSB-first on MISO.
- Sits between the SPI pins and the RAM; it is the only master of the RAM's din/rx_valid port.

Parameters:
ADDR_SIZE, 8, RAM address/data width; command word width is ADDR_SIZE+2.

Ports:
clk  in  1  clock (SPI SCK domain; all logic on rising edge)
rst_n  in  1  synchronous, active-low reset
SS_n  in  1  slave select, active-low
MOSI  in  1  serial data in, sampled on rising clk
MISO  out  1  serial data out, registered
rx_data  out  ADDR_SIZE+2  command word to RAM (bits[9:8] = opcode 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data)
rx_valid  out  1  one-cycle strobe; rx_data valid
tx_data  in  ADDR_SIZE  read data from RAM
tx_valid  in  1  RAM read data valid

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; MISO=0, rx_data=0, rx_valid=0; bit counter=0; rd_addr_rcvd=0; tx shift reg cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE -> CHK_CMD when SS_n=0; otherwise stay.
- CHK_CMD, SS_n=0:
  - MOSI is consumed as word bit 9.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_rcvd=0 -> READ_ADD.
  - MOSI=1 and rd_addr_rcvd=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA shift in the remaining 9 bits, MSB-first, one per clk.
  - On the cycle the 10th bit is sampled, rx_data <= full word and rx_valid <= 1 on the same edge.
  - rx_valid is therefore high exactly one cycle; rx_data holds until the next word completes.
  - Word contents are forwarded unchecked; opcode bits come from MOSI.
- rd_addr_rcvd: set when a READ_ADD word completes; cleared when a READ_DATA word completes.
- After a word completes in WRITE or READ_ADD, the FSM idles in that state (no further shifting) until SS_n=1.
- READ_DATA after word completion (waiting for reply):
  - First cycle with tx_valid=1: load tx_data into the shift reg and drive MISO <= tx_data[7] at that edge.
  - Next 7 cycles: MISO = bits 6..0.
  - Then MISO <= 0 and hold.
  - tx_valid seen before word completion is ignored; only one load per transaction.
- Expected RAM timing: tx_valid is 1 cycle after rx_valid. So MISO bit7 appears 2 cycles after rx_valid, and the last bit 9 cycles after rx_valid.
- SS_n=1 in any non-IDLE state:
  - Next state IDLE; counter and shift state cleared; MISO <= 0.
  - rx_valid is not asserted for a partial word.
  - rd_addr_rcvd is retained.
- SS_n low for longer than a full frame is legal; extra MOSI bits are ignored.
- Counter is 4 bits, saturating; no wrap within a frame.
- Reset mid-frame: all state returns to reset values on that edge; a partially shifted word is discarded.

Decomposition:
- Package spi_ram_pkg holds:
  - state encoding localparams (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - WORD_W = ADDR_SIZE+2.
- One sub-module, spi_tx_serializer:
  - ADDR_SIZE-bit load/shift register with a 3-bit count.
  - Inputs: load, din, en. Outputs: MISO, busy.
- FSM, rx shift, and rd_addr_rcvd flag live in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with SS_n=0, MOSI toggling -> MISO=0, rx_valid=0, rx_data=0; after release, state IDLE until SS_n falls.
- Write-address frame: shift 10'b00_1010_0101 -> exactly one rx_valid pulse with rx_data=10'h0A5, asserted on the 10th-bit edge; then SS_n=1 -> IDLE.
- Write-data frame: shift 10'b01_0011_1100 -> rx_data=10'h13C, one pulse; rd_addr_rcvd stays 0.
- Read sequence: frame 10'b10_1010_0101 (rx_data=10'h2A5, rd_addr_rcvd=1); new frame 10'b11_0000_0000 enters READ_DATA; RAM model returns tx_data=8'h3C one cycle after rx_valid -> MISO=0,0,1,1,1,1,0,0 on the 8 following cycles, then 0; rd_addr_rcvd=0 afterwards.
- Abort: SS_n rises after 5 bits of 10'b00_1111_0000 -> no rx_valid, IDLE next cycle; next full frame 10'h0F0 decodes correctly.
- Read ordering: two consecutive MOSI=1 frames with no prior rd-addr -> first routed via READ_ADD, second via READ_DATA; a third MOSI=1 frame is routed via READ_ADD again.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared types and constants for the SPI RAM slave controller
package spi_ram_pkg;

    localparam int DEF_ADDR_SIZE = 8;
    localparam int WORD_W        = DEF_ADDR_SIZE + 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CHK_CMD   = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_READ_ADD  = 3'd3;
    localparam logic [2:0] ST_READ_DATA = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        CHK_CMD   = ST_CHK_CMD,
        WRITE     = ST_WRITE,
        READ_ADD  = ST_READ_ADD,
        READ_DATA = ST_READ_DATA
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_slave_ctrl_if.sv
// rtl/spi_ram_slave_ctrl_if.sv - SPI pins plus RAM command/reply port
interface spi_ram_slave_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic                   SS_n;
    logic                   MOSI;
    logic                   MISO;
    logic [ADDR_SIZE+1:0]   rx_data;
    logic                   rx_valid;
    logic [ADDR_SIZE-1:0]   tx_data;
    logic                   tx_valid;

    // Controller side: consumes the pins and the RAM reply, drives the RAM command
    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid
    );

    // SPI master and RAM side as seen from outside the controller
    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - load/shift register driving MISO MSB-first
module spi_tx_serializer #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 en,
    input  logic [ADDR_SIZE-1:0] din,
    output logic                 MISO,
    output logic                 busy
);
    localparam int CW = (ADDR_SIZE > 2) ? $clog2(ADDR_SIZE) : 1;

    logic [ADDR_SIZE-1:0] sh;
    logic [CW-1:0]        cnt;

    // MSB goes out on the load edge; the remaining bits follow one per cycle, then MISO parks at 0
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sh   <= '0;
            cnt  <= '0;
            MISO <= 1'b0;
        end else if (load) begin
            MISO <= din[ADDR_SIZE-1];
            sh   <= {din[ADDR_SIZE-2:0], 1'b0};
            cnt  <= CW'(ADDR_SIZE - 1);
        end else if (en) begin
            if (cnt != '0) begin
                MISO <= sh[ADDR_SIZE-1];
                sh   <= {sh[ADDR_SIZE-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
            end else begin
                MISO <= 1'b0;
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/spi_ram_slave_ctrl.sv
// rtl/spi_ram_slave_ctrl.sv - SPI slave that deserialises RAM commands and returns read data
module spi_ram_slave_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_ram_slave_ctrl_if.slave  bus
);
    localparam int W     = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [W-2:0]     rx_sh;
    logic [W-1:0]     rx_data_q;
    logic             rx_valid_q;
    logic             rd_addr_rcvd;
    logic             tx_loaded;
    logic             tx_load;
    logic             tx_busy;
    logic             miso_w;
    logic             in_word_state;

    assign in_word_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    // A reply is accepted once per frame, only after the rd-data word has fully arrived
    assign tx_load = !bus.SS_n && (state == READ_DATA) && (bit_cnt == CNT_FULL)
                     && bus.tx_valid && !tx_loaded && !tx_busy;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: first MOSI bit picks the branch, rd_addr_rcvd splits reads into addr/data
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!bus.SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)          next_state = IDLE;
                else if (!bus.MOSI)    next_state = WRITE;
                else if (rd_addr_rcvd) next_state = READ_DATA;
                else                   next_state = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Receive shifter, word strobe and read-address tracking; deselect drops any partial word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_sh        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rd_addr_rcvd <= 1'b0;
            tx_loaded    <= 1'b0;
        end else if (bus.SS_n) begin
            bit_cnt    <= '0;
            rx_sh      <= '0;
            rx_valid_q <= 1'b0;
            tx_loaded  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tx_load) tx_loaded <= 1'b1;
            if (state == CHK_CMD) begin
                rx_sh   <= {{(W-2){1'b0}}, bus.MOSI};
                bit_cnt <= CNT_W'(1);
            end else if (in_word_state && (bit_cnt < CNT_FULL)) begin
                rx_sh   <= {rx_sh[W-3:0], bus.MOSI};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == CNT_LAST) begin
                    rx_data_q  <= {rx_sh, bus.MOSI};
                    rx_valid_q <= 1'b1;
                    if (state == READ_ADD)  rd_addr_rcvd <= 1'b1;
                    if (state == READ_DATA) rd_addr_rcvd <= 1'b0;
                end
            end
        end
    end

    spi_tx_serializer #(.ADDR_SIZE(ADDR_SIZE)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.SS_n),
        .load  (tx_load),
        .en    (state == READ_DATA),
        .din   (bus.tx_data),
        .MISO  (miso_w),
        .busy  (tx_busy)
    );

    assign bus.MISO     = miso_w;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_ram_slave_ctrl.sv
// tb/tb_spi_ram_slave_ctrl.sv - directed self-checking bench for spi_ram_slave_ctrl
module tb_spi_ram_slave_ctrl;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_ram_slave_ctrl_if #(.ADDR_SIZE(8)) bus ();

    spi_ram_slave_ctrl #(.ADDR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int p0;
    logic [2:0] route;
    logic [7:0] ram_rd_val = 8'h3C;
    logic [7:0] exp_byte;

    // RAM model: registered reply one cycle after an rd-data command strobe
    always @(posedge clk) begin
        if (bus.rx_valid) pulse_cnt <= pulse_cnt + 1;
        bus.tx_valid <= rst_n && bus.rx_valid && (bus.rx_data[9:8] == OP_RD_DATA);
        bus.tx_data  <= ram_rd_val;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [9:0] w, input int nbits, output logic [2:0] rt);
        bus.SS_n = 1'b0;
        rt = 3'd7;
        tick;
        for (int i = 9; i > 9 - nbits; i--) begin
            bus.MOSI = w[i];
            tick;
            if (i == 9) rt = dut.state;
        end
    endtask

    task automatic end_frame(input string tag);
        bus.SS_n = 1'b1;
        tick;
        check(tag, {29'd0, dut.state}, {29'd0, ST_IDLE});
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.MOSI = ~bus.MOSI;
            tick;
        end
        check("reset_miso",     {31'd0, bus.MISO}, 32'd0);
        check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_rx_data",  {22'd0, bus.rx_data}, 32'd0);
        check("reset_state",    {29'd0, dut.state}, {29'd0, ST_IDLE});

        rst_n    = 1'b1;
        bus.SS_n = 1'b1;
        tick;
        tick;
        check("idle_hold", {29'd0, dut.state}, {29'd0, ST_IDLE});

        // write-address frame
        p0 = pulse_cnt;
        send_frame(10'h0A5, 10, route);
        check("wa_route", {29'd0, route}, {29'd0, ST_WRITE});
        check("wa_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("wa_data",  {22'd0, bus.rx_data}, 32'h0A5);
        bus.MOSI = 1'b1;
        tick;
        check("wa_valid_low", {31'd0, bus.rx_valid}, 32'd0);
        check("wa_pulses",    pulse_cnt - p0, 32'd1);
        check("wa_data_hold", {22'd0, bus.rx_data}, 32'h0A5);
        end_frame("wa_idle");

        // write-data frame
        send_frame(10'h13C, 10, route);
        check("wd_route", {29'd0, route}, {29'd0, ST_WRITE});
        check("wd_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("wd_data",  {22'd0, bus.rx_data}, 32'h13C);
        check("wd_rdflag", {31'd0, dut.rd_addr_rcvd}, 32'd0);
        end_frame("wd_idle");

        // read address then read data
        send_frame(10'h2A5, 10, route);
        check("ra_route", {29'd0, route}, {29'd0, ST_READ_ADD});
        check("ra_data",  {22'd0, bus.rx_data}, 32'h2A5);
        check("ra_rdflag", {31'd0, dut.rd_addr_rcvd}, 32'd1);
        end_frame("ra_idle");
        check("ra_rdflag_kept", {31'd0, dut.rd_addr_rcvd}, 32'd1);

        p0 = pulse_cnt;
        send_frame(10'h300, 10, route);
        check("rd_route", {29'd0, route}, {29'd0, ST_READ_DATA});
        check("rd_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("rd_data",  {22'd0, bus.rx_data}, 32'h300);
        check("rd_rdflag", {31'd0, dut.rd_addr_rcvd}, 32'd0);
        bus.MOSI = 1'b1;
        tick;
        check("rd_miso_wait", {31'd0, bus.MISO}, 32'd0);
        exp_byte = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            tick;
            check($sformatf("rd_miso_bit%0d", i), {31'd0, bus.MISO}, {31'd0, exp_byte[i]});
        end
        tick;
        check("rd_miso_tail0", {31'd0, bus.MISO}, 32'd0);
        tick;
        check("rd_miso_tail1", {31'd0, bus.MISO}, 32'd0);
        check("rd_pulses", pulse_cnt - p0, 32'd1);
        end_frame("rd_idle");

        // abort after 5 bits
        p0 = pulse_cnt;
        send_frame(10'h0F0, 5, route);
        check("ab_route", {29'd0, route}, {29'd0, ST_WRITE});
        bus.SS_n = 1'b1;
        tick;
        check("ab_state",    {29'd0, dut.state}, {29'd0, ST_IDLE});
        check("ab_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        tick;
        check("ab_pulses",   pulse_cnt - p0, 32'd0);
        check("ab_data_hold", {22'd0, bus.rx_data}, 32'h300);
        send_frame(10'h0F0, 10, route);
        check("ab_next_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("ab_next_data",  {22'd0, bus.rx_data}, 32'h0F0);
        end_frame("ab_idle");

        // read ordering
        send_frame(10'h2C3, 10, route);
        check("ord1_route", {29'd0, route}, {29'd0, ST_READ_ADD});
        end_frame("ord1_idle");
        send_frame(10'h3FF, 10, route);
        check("ord2_route", {29'd0, route}, {29'd0, ST_READ_DATA});
        end_frame("ord2_idle");
        tick;
        check("ord2_miso", {31'd0, bus.MISO}, 32'd0);
        send_frame(10'h25A, 10, route);
        check("ord3_route", {29'd0, route}, {29'd0, ST_READ_ADD});
        check("ord3_data",  {22'd0, bus.rx_data}, 32'h25A);
        end_frame("ord3_idle");

        // reset mid-frame
        send_frame(10'h1FF, 6, route);
        rst_n = 1'b0;
        tick;
        check("mrst_state",  {29'd0, dut.state}, {29'd0, ST_IDLE});
        check("mrst_data",   {22'd0, bus.rx_data}, 32'd0);
        check("mrst_rdflag", {31'd0, dut.rd_addr_rcvd}, 32'd0);
        check("mrst_miso",   {31'd0, bus.MISO}, 32'd0);
        rst_n    = 1'b1;
        bus.SS_n = 1'b1;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
